// File: rtl/id_pkg.sv
// Shared constants for the ID-stage decoder: class indices, MIPS opcode/func
// encodings, stage state encoding and class-group helpers.
package id_pkg;

  localparam logic [5:0] C_ADD     = 6'd0;
  localparam logic [5:0] C_ADDU    = 6'd1;
  localparam logic [5:0] C_SUB     = 6'd2;
  localparam logic [5:0] C_SUBU    = 6'd3;
  localparam logic [5:0] C_AND     = 6'd4;
  localparam logic [5:0] C_OR      = 6'd5;
  localparam logic [5:0] C_XOR     = 6'd6;
  localparam logic [5:0] C_NOR     = 6'd7;
  localparam logic [5:0] C_SLT     = 6'd8;
  localparam logic [5:0] C_SLTU    = 6'd9;
  localparam logic [5:0] C_SLL     = 6'd10;
  localparam logic [5:0] C_SRL     = 6'd11;
  localparam logic [5:0] C_SRA     = 6'd12;
  localparam logic [5:0] C_SLLV    = 6'd13;
  localparam logic [5:0] C_SRLV    = 6'd14;
  localparam logic [5:0] C_SRAV    = 6'd15;
  localparam logic [5:0] C_JR      = 6'd16;
  localparam logic [5:0] C_ADDI    = 6'd17;
  localparam logic [5:0] C_ADDIU   = 6'd18;
  localparam logic [5:0] C_ANDI    = 6'd19;
  localparam logic [5:0] C_ORI     = 6'd20;
  localparam logic [5:0] C_XORI    = 6'd21;
  localparam logic [5:0] C_LW      = 6'd22;
  localparam logic [5:0] C_SW      = 6'd23;
  localparam logic [5:0] C_BEQ     = 6'd24;
  localparam logic [5:0] C_BNE     = 6'd25;
  localparam logic [5:0] C_SLTI    = 6'd26;
  localparam logic [5:0] C_SLTIU   = 6'd27;
  localparam logic [5:0] C_LUI     = 6'd28;
  localparam logic [5:0] C_J       = 6'd29;
  localparam logic [5:0] C_JAL     = 6'd30;
  localparam logic [5:0] C_JALR    = 6'd31;
  localparam logic [5:0] C_CLZ     = 6'd32;
  localparam logic [5:0] C_BGEZ    = 6'd33;
  localparam logic [5:0] C_LB      = 6'd34;
  localparam logic [5:0] C_LBU     = 6'd35;
  localparam logic [5:0] C_LH      = 6'd36;
  localparam logic [5:0] C_LHU     = 6'd37;
  localparam logic [5:0] C_SB      = 6'd38;
  localparam logic [5:0] C_SH      = 6'd39;
  localparam logic [5:0] C_MFC0    = 6'd40;
  localparam logic [5:0] C_MTC0    = 6'd41;
  localparam logic [5:0] C_MFHI    = 6'd42;
  localparam logic [5:0] C_MTHI    = 6'd43;
  localparam logic [5:0] C_MFLO    = 6'd44;
  localparam logic [5:0] C_MTLO    = 6'd45;
  localparam logic [5:0] C_MUL     = 6'd46;
  localparam logic [5:0] C_MULTU   = 6'd47;
  localparam logic [5:0] C_DIV     = 6'd48;
  localparam logic [5:0] C_DIVU    = 6'd49;
  localparam logic [5:0] C_SYSCALL = 6'd50;
  localparam logic [5:0] C_TEQ     = 6'd51;
  localparam logic [5:0] C_BREAK   = 6'd52;
  localparam logic [5:0] C_ERET    = 6'd53;

  localparam logic [5:0] IDX_ILLEGAL = 6'd63;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_COP0     = 6'b010000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_ERET    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;
  localparam logic [5:0] FN_TEQ     = 6'b110100;
  localparam logic [5:0] FN2_MUL    = 6'b000010;
  localparam logic [5:0] FN2_CLZ    = 6'b100000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FULL   = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;

  function automatic logic is_load_cls(logic [5:0] c);
    return c inside {C_LW, C_LB, C_LBU, C_LH, C_LHU};
  endfunction

  function automatic logic is_cop0_cls(logic [5:0] c);
    return c inside {C_MFC0, C_MTC0, C_ERET, C_SYSCALL, C_BREAK, C_TEQ};
  endfunction

  function automatic logic is_mdu_cls(logic [5:0] c);
    return c inside {C_MUL, C_MULTU, C_DIV, C_DIVU, C_MFHI, C_MTHI, C_MFLO, C_MTLO, C_CLZ};
  endfunction

endpackage

// File: rtl/id_class_lut.sv
// Combinational instruction-class lookup: instruction word to class index,
// with optional COP0 and MDU subsets reported as illegal when disabled.
module id_class_lut
  import id_pkg::*;
#(
  parameter bit EN_COP0 = 1'b1,
  parameter bit EN_MDU  = 1'b1
) (
  input  logic [31:0] instr,
  output logic [5:0]  idx,
  output logic        illegal
);

  logic [5:0] op, fn, raw;
  logic [4:0] rs, rt;
  logic       unused_rd;

  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign fn        = instr[5:0];
  assign unused_rd = ^instr[15:11];

  always_comb begin
    raw = IDX_ILLEGAL;
    case (op)
      OP_SPECIAL:
        case (fn)
          FN_ADD:     raw = C_ADD;
          FN_ADDU:    raw = C_ADDU;
          FN_SUB:     raw = C_SUB;
          FN_SUBU:    raw = C_SUBU;
          FN_AND:     raw = C_AND;
          FN_OR:      raw = C_OR;
          FN_XOR:     raw = C_XOR;
          FN_NOR:     raw = C_NOR;
          FN_SLT:     raw = C_SLT;
          FN_SLTU:    raw = C_SLTU;
          FN_SLL:     raw = C_SLL;
          FN_SRL:     raw = C_SRL;
          FN_SRA:     raw = C_SRA;
          FN_SLLV:    raw = C_SLLV;
          FN_SRLV:    raw = C_SRLV;
          FN_SRAV:    raw = C_SRAV;
          FN_JR:      raw = C_JR;
          FN_JALR:    raw = C_JALR;
          FN_MFHI:    raw = C_MFHI;
          FN_MTHI:    raw = C_MTHI;
          FN_MFLO:    raw = C_MFLO;
          FN_MTLO:    raw = C_MTLO;
          FN_MULTU:   raw = C_MULTU;
          FN_DIV:     raw = C_DIV;
          FN_DIVU:    raw = C_DIVU;
          FN_SYSCALL: raw = C_SYSCALL;
          FN_BREAK:   raw = C_BREAK;
          FN_TEQ:     raw = C_TEQ;
          default:    raw = IDX_ILLEGAL;
        endcase
      OP_REGIMM:   if (rt == RT_BGEZ) raw = C_BGEZ;
      OP_COP0:
        if (rs == 5'b00000 && instr[10:0] == '0)      raw = C_MFC0;
        else if (rs == 5'b00100 && instr[10:0] == '0) raw = C_MTC0;
        else if (rs == 5'b10000 && fn == FN_ERET)      raw = C_ERET;
      OP_SPECIAL2:
        if (fn == FN2_CLZ)      raw = C_CLZ;
        else if (fn == FN2_MUL) raw = C_MUL;
      OP_ADDI:  raw = C_ADDI;
      OP_ADDIU: raw = C_ADDIU;
      OP_ANDI:  raw = C_ANDI;
      OP_ORI:   raw = C_ORI;
      OP_XORI:  raw = C_XORI;
      OP_LW:    raw = C_LW;
      OP_SW:    raw = C_SW;
      OP_BEQ:   raw = C_BEQ;
      OP_BNE:   raw = C_BNE;
      OP_SLTI:  raw = C_SLTI;
      OP_SLTIU: raw = C_SLTIU;
      OP_LUI:   raw = C_LUI;
      OP_J:     raw = C_J;
      OP_JAL:   raw = C_JAL;
      OP_LB:    raw = C_LB;
      OP_LBU:   raw = C_LBU;
      OP_LH:    raw = C_LH;
      OP_LHU:   raw = C_LHU;
      OP_SB:    raw = C_SB;
      OP_SH:    raw = C_SH;
      default:  raw = IDX_ILLEGAL;
    endcase
  end

  // Disabled subsets are filtered after lookup so the table stays uniform.
  assign idx = ((is_cop0_cls(raw) && !EN_COP0) || (is_mdu_cls(raw) && !EN_MDU))
               ? IDX_ILLEGAL : raw;
  assign illegal = (idx == IDX_ILLEGAL);

endmodule

// File: rtl/id_stage_decoder.sv
// Registered ID stage: valid/ready handshake around the class lookup, with
// load-use bubble insertion and synchronous flush.
module id_stage_decoder
  import id_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned IC_W        = 54,
  parameter bit          EN_COP0     = 1'b1,
  parameter bit          EN_MDU      = 1'b1,
  parameter bit          EN_LU_STALL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IC_W-1:0] out_ic,
  output logic [5:0]      out_idx,
  output logic            out_illegal,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_sa,
  output logic [15:0]     out_imm,
  output logic [PC_W-1:0] out_pc
);

  logic [1:0]      state;
  logic [5:0]      dec_idx;
  logic            dec_ill;
  logic [IC_W-1:0] dec_ic;
  logic            xfer, acc, hazard, prev_v, trk_v;
  logic [4:0]      prev_rt, trk_rt;

  id_class_lut #(
    .EN_COP0(EN_COP0),
    .EN_MDU (EN_MDU)
  ) u_lut (
    .instr  (in_instr),
    .idx    (dec_idx),
    .illegal(dec_ill)
  );

  always_comb begin
    dec_ic = '0;
    for (int unsigned i = 0; i < IC_W; i++)
      dec_ic[i] = !dec_ill && (32'(dec_idx) == i);
  end

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !flush && (state == ST_EMPTY || (state == ST_FULL && out_ready));
  assign xfer      = !flush && (state == ST_FULL) && out_ready;
  assign acc       = in_valid && in_ready;

  // The instruction leaving this cycle is the producer to compare against;
  // it has not reached the tracker yet.
  assign prev_v  = xfer ? is_load_cls(out_idx) : trk_v;
  assign prev_rt = xfer ? out_rt : trk_rt;
  assign hazard  = EN_LU_STALL && prev_v && (prev_rt != '0) &&
                   (in_instr[25:21] == prev_rt || in_instr[20:16] == prev_rt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      trk_v       <= 1'b0;
      trk_rt      <= '0;
      out_ic      <= '0;
      out_idx     <= IDX_ILLEGAL;
      out_illegal <= 1'b0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_sa      <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
      trk_v <= 1'b0;
    end else begin
      if (xfer) begin
        trk_v  <= is_load_cls(out_idx);
        trk_rt <= out_rt;
      end
      if (acc) begin
        state       <= hazard ? ST_BUBBLE : ST_FULL;
        out_ic      <= dec_ic;
        out_idx     <= dec_idx;
        out_illegal <= dec_ill;
        out_rs      <= in_instr[25:21];
        out_rt      <= in_instr[20:16];
        out_rd      <= in_instr[15:11];
        out_sa      <= in_instr[10:6];
        out_imm     <= in_instr[15:0];
        out_pc      <= in_pc;
      end else if (state == ST_BUBBLE) begin
        state <= ST_FULL;
      end else if (xfer) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_decoder.sv
// Bench for id_stage_decoder: two instances (all features on / all optional
// features off) driven in lockstep and checked against a reference model.
module tb_id_stage_decoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_ir, a_ov, a_ill, b_ir, b_ov, b_ill;
  logic [53:0] a_ic, b_ic;
  logic [5:0]  a_idx, b_idx;
  logic [4:0]  a_rs, a_rt, a_rd, a_sa, b_rs, b_rt, b_rd, b_sa;
  logic [15:0] a_imm, b_imm;
  logic [31:0] a_pc, b_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage_decoder #(.PC_W(32), .IC_W(54), .EN_COP0(1'b1), .EN_MDU(1'b1), .EN_LU_STALL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_ov), .out_ready(out_ready),
    .out_ic(a_ic), .out_idx(a_idx), .out_illegal(a_ill), .out_rs(a_rs), .out_rt(a_rt),
    .out_rd(a_rd), .out_sa(a_sa), .out_imm(a_imm), .out_pc(a_pc));

  id_stage_decoder #(.PC_W(32), .IC_W(54), .EN_COP0(1'b0), .EN_MDU(1'b0), .EN_LU_STALL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_ov), .out_ready(out_ready),
    .out_ic(b_ic), .out_idx(b_idx), .out_illegal(b_ill), .out_rs(b_rs), .out_rt(b_rt),
    .out_rd(b_rd), .out_sa(b_sa), .out_imm(b_imm), .out_pc(b_pc));

  // Encoding table: an instruction belongs to a class when (instr & mask) == match.
  // grp 1 = COP0 subset, grp 2 = MDU subset.
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          idx;
    int          grp;
  } pat_t;
  pat_t tbl[$];

  bit p_cop0[2] = '{1'b1, 1'b0};
  bit p_mdu[2]  = '{1'b1, 1'b0};
  bit p_lu[2]   = '{1'b1, 1'b0};

  bit          m_occ[2], m_bub[2], m_tv[2], m_ill[2];
  logic [4:0]  m_trt[2];
  int          m_idx[2];
  logic [35:0] m_fld[2];
  logic [31:0] m_pc[2];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(logic [31:0] mask, logic [31:0] match, int idx, int grp);
    pat_t p;
    p.mask = mask; p.match = match; p.idx = idx; p.grp = grp;
    tbl.push_back(p);
  endtask

  task automatic add_r(logic [5:0] fn, int idx, int grp);
    add(32'hFC00003F, {26'd0, fn}, idx, grp);
  endtask

  task automatic add_i(logic [5:0] op, int idx);
    add(32'hFC000000, {op, 26'd0}, idx, 0);
  endtask

  task automatic build_table();
    add_r(6'h20, 0, 0);  add_r(6'h21, 1, 0);  add_r(6'h22, 2, 0);  add_r(6'h23, 3, 0);
    add_r(6'h24, 4, 0);  add_r(6'h25, 5, 0);  add_r(6'h26, 6, 0);  add_r(6'h27, 7, 0);
    add_r(6'h2A, 8, 0);  add_r(6'h2B, 9, 0);  add_r(6'h00, 10, 0); add_r(6'h02, 11, 0);
    add_r(6'h03, 12, 0); add_r(6'h04, 13, 0); add_r(6'h06, 14, 0); add_r(6'h07, 15, 0);
    add_r(6'h08, 16, 0); add_r(6'h09, 31, 0);
    add_r(6'h10, 42, 2); add_r(6'h11, 43, 2); add_r(6'h12, 44, 2); add_r(6'h13, 45, 2);
    add_r(6'h19, 47, 2); add_r(6'h1A, 48, 2); add_r(6'h1B, 49, 2);
    add_r(6'h0C, 50, 1); add_r(6'h34, 51, 1); add_r(6'h0D, 52, 1);
    add_i(6'h08, 17); add_i(6'h09, 18); add_i(6'h0C, 19); add_i(6'h0D, 20);
    add_i(6'h0E, 21); add_i(6'h23, 22); add_i(6'h2B, 23); add_i(6'h04, 24);
    add_i(6'h05, 25); add_i(6'h0A, 26); add_i(6'h0B, 27); add_i(6'h0F, 28);
    add_i(6'h02, 29); add_i(6'h03, 30); add_i(6'h20, 34); add_i(6'h24, 35);
    add_i(6'h21, 36); add_i(6'h25, 37); add_i(6'h28, 38); add_i(6'h29, 39);
    add(32'hFC1F0000, 32'h04010000, 33, 0);
    add(32'hFFE007FF, 32'h40000000, 40, 1);
    add(32'hFFE007FF, 32'h40800000, 41, 1);
    add(32'hFFE0003F, 32'h42000018, 53, 1);
    add(32'hFC00003F, 32'h70000020, 32, 2);
    add(32'hFC00003F, 32'h70000002, 46, 2);
  endtask

  function automatic int ref_idx(logic [31:0] ins, int k);
    foreach (tbl[j]) begin
      if ((ins & tbl[j].mask) == tbl[j].match) begin
        if (tbl[j].grp == 1 && !p_cop0[k]) return 63;
        if (tbl[j].grp == 2 && !p_mdu[k]) return 63;
        return tbl[j].idx;
      end
    end
    return 63;
  endfunction

  function automatic bit is_ld(int idx);
    return idx == 22 || idx == 34 || idx == 35 || idx == 36 || idx == 37;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int j;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    j = $urandom_range(0, tbl.size() - 1);
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return (w & ~tbl[j].mask) | tbl[j].match;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_occ[k] = 0; m_bub[k] = 0; m_tv[k] = 0; m_trt[k] = '0;
      m_idx[k] = 63; m_ill[k] = 0; m_fld[k] = '0; m_pc[k] = '0;
    end
  endtask

  task automatic check_dut(int k, logic ov, logic ir, logic [53:0] ic, logic [5:0] idx,
                           logic ill, logic [35:0] fld, logic [31:0] pc);
    string       nm;
    bit          eov, eir;
    logic [63:0] eic;
    nm  = (k == 0) ? "A" : "B";
    eov = m_occ[k] && !m_bub[k];
    eir = !flush && (!m_occ[k] || (!m_bub[k] && out_ready));
    eic = (m_ill[k] || m_idx[k] == 63) ? 64'd0 : (64'd1 << m_idx[k]);
    check({nm, ".out_valid"}, {63'd0, ov}, {63'd0, eov});
    check({nm, ".in_ready"}, {63'd0, ir}, {63'd0, eir});
    check({nm, ".out_ic"}, {10'd0, ic}, eic);
    check({nm, ".out_idx"}, {58'd0, idx}, 64'(m_idx[k]));
    check({nm, ".out_illegal"}, {63'd0, ill}, {63'd0, m_ill[k]});
    check({nm, ".fields"}, {28'd0, fld}, {28'd0, m_fld[k]});
    check({nm, ".out_pc"}, {32'd0, pc}, {32'd0, m_pc[k]});
  endtask

  task automatic model_step(int k);
    bit ov, ir, xf, ac, pv;
    logic [4:0] prt;
    ov = m_occ[k] && !m_bub[k];
    ir = !flush && (!m_occ[k] || (!m_bub[k] && out_ready));
    if (flush) begin
      m_occ[k] = 0; m_bub[k] = 0; m_tv[k] = 0;
      return;
    end
    xf  = ov && out_ready;
    ac  = in_valid && ir;
    pv  = xf ? is_ld(m_idx[k]) : m_tv[k];
    prt = xf ? m_fld[k][30:26] : m_trt[k];
    if (xf) begin
      m_tv[k]  = is_ld(m_idx[k]);
      m_trt[k] = m_fld[k][30:26];
    end
    if (ac) begin
      m_bub[k] = p_lu[k] && pv && prt != 0 &&
                 (in_instr[25:21] == prt || in_instr[20:16] == prt);
      m_occ[k] = 1;
      m_idx[k] = ref_idx(in_instr, k);
      m_ill[k] = (m_idx[k] == 63);
      m_fld[k] = {in_instr[25:21], in_instr[20:16], in_instr[15:11], in_instr[10:6], in_instr[15:0]};
      m_pc[k]  = in_pc;
    end else if (m_bub[k]) begin
      m_bub[k] = 0;
    end else if (xf) begin
      m_occ[k] = 0;
    end
  endtask

  task automatic drive(logic iv, logic [31:0] ins, logic [31:0] pc, logic ordy, logic fl);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  // Called at posedge+1: checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic tick();
    #3;
    if (rst) begin
      model_reset();
    end else begin
      check_dut(0, a_ov, a_ir, a_ic, a_idx, a_ill, {a_rs, a_rt, a_rd, a_sa, a_imm}, a_pc);
      check_dut(1, b_ov, b_ir, b_ic, b_idx, b_ill, {b_rs, b_rt, b_rd, b_sa, b_imm}, b_pc);
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    build_table();
    model_reset();
    rst = 1'b1;
    drive(0, '0, '0, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst.idx", {58'd0, a_idx}, 64'd63);
    check("rst.in_ready", {63'd0, a_ir}, 64'd1);
    check("rst.out_valid", {63'd0, a_ov}, 64'd0);
    check("rst.ic", {10'd0, a_ic}, 64'd0);

    drive(1, 32'h00221820, 32'h100, 1, 0); tick();
    check("add.valid", {63'd0, a_ov}, 64'd1);
    check("add.idx", {58'd0, a_idx}, 64'd0);
    check("add.ic", {10'd0, a_ic}, 64'd1);
    check("add.rsrtrd", {49'd0, a_rs, a_rt, a_rd}, {49'd0, 5'd1, 5'd2, 5'd3});

    drive(1, 32'h8C220000, 32'h104, 1, 0); tick();
    check("lw.idx", {58'd0, a_idx}, 64'd22);
    drive(1, 32'h00422020, 32'h108, 1, 0); tick();
    check("lu.bubble", {63'd0, a_ov}, 64'd0);
    check("lu.nostall.valid", {63'd0, b_ov}, 64'd1);
    check("lu.nostall.idx", {58'd0, b_idx}, 64'd0);
    drive(0, '0, '0, 1, 0); tick();
    check("lu.after.valid", {63'd0, a_ov}, 64'd1);
    check("lu.after.idx", {58'd0, a_idx}, 64'd0);
    check("lu.after.pc", {32'd0, a_pc}, 64'h108);

    drive(1, 32'h42000018, 32'h10C, 1, 0); tick();
    check("eret.idx", {58'd0, a_idx}, 64'd53);
    check("eret.off.ill", {63'd0, b_ill}, 64'd1);
    drive(1, 32'h40086000, 32'h110, 1, 0); tick();
    check("mfc0.idx", {58'd0, a_idx}, 64'd40);
    check("mfc0.rtrd", {54'd0, a_rt, a_rd}, {54'd0, 5'd8, 5'd12});
    drive(1, 32'h42000000, 32'h114, 1, 0); tick();
    check("cop0bad.ill", {63'd0, a_ill}, 64'd1);
    check("cop0bad.ic", {10'd0, a_ic}, 64'd0);
    check("cop0bad.idx", {58'd0, a_idx}, 64'd63);
    drive(1, 32'h0000001B, 32'h118, 1, 0); tick();
    check("divu.idx", {58'd0, a_idx}, 64'd49);
    check("divu.off.ill", {63'd0, b_ill}, 64'd1);
    check("divu.off.ic", {10'd0, b_ic}, 64'd0);

    drive(1, 32'h00221820, 32'h200, 1, 0); tick();
    drive(1, 32'h00853020, 32'h204, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.valid", {63'd0, a_ov}, 64'd1);
      check("hold.pc", {32'd0, a_pc}, 64'h200);
      check("hold.in_ready", {63'd0, a_ir}, 64'd0);
    end
    drive(1, 32'h00853020, 32'h204, 1, 0);
    #1 check("release.in_ready", {63'd0, a_ir}, 64'd1);
    tick();
    check("release.valid", {63'd0, a_ov}, 64'd1);
    check("release.pc", {32'd0, a_pc}, 64'h204);

    drive(1, 32'h8C220000, 32'h300, 1, 0); tick();
    drive(1, 32'h00422020, 32'h304, 1, 0); tick();
    check("flush.pre.bubble", {63'd0, a_ov}, 64'd0);
    drive(1, 32'h00422020, 32'h306, 1, 1); tick();
    drive(0, '0, '0, 1, 0);
    #1;
    check("flush.valid", {63'd0, a_ov}, 64'd0);
    check("flush.in_ready", {63'd0, a_ir}, 64'd1);
    drive(1, 32'h00422020, 32'h308, 1, 0); tick();
    check("flush.nobubble.valid", {63'd0, a_ov}, 64'd1);
    check("flush.nobubble.pc", {32'd0, a_pc}, 64'h308);

    drive(1, 32'h8C220000, 32'h400, 1, 0); tick();
    drive(0, '0, '0, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", {63'd0, a_ov}, 64'd0);
    check("arst.idx", {58'd0, a_idx}, 64'd63);
    check("arst.b.valid", {63'd0, b_ov}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 32'h00422020, 32'h404, 1, 0); tick();
    check("arst.nobubble.valid", {63'd0, a_ov}, 64'd1);
    check("arst.nobubble.pc", {32'd0, a_pc}, 64'h404);

    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 9) < 7, gen_instr(), $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
